// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the two-requester memory arbiter.
package mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way grant picker, one-hot output.
// MEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie (last grant ignored).
module mem_arb_rr
    import mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
`ifdef MEM_ARB_FIXED_PRIO_EN
            2'b11: o_grant = 2'b01;
`else
            // Tie goes to whoever did not win last time.
            2'b11: o_grant = i_last_grant ? 2'b01 : 2'b10;
`endif
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 8x8 memory between two requesters.
// Tie-break policy switchable via MEM_ARB_FIXED_PRIO_EN (see mem_arb_rr).
module mem_arbiter #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 3,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_mem_select,
    output logic              o_mem_op,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    import mem_pkg::*;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    arb_state_t        r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic [1:0]        r_ack, w_ack_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_sel, w_sel_nxt;
    logic              r_op, w_op_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [1:0]        w_grant;

    mem_arb_rr u_rr (
        .i_req        (i_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_ack        <= 2'b00;
            r_rdata      <= '0;
            r_sel        <= 1'b0;
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_sel        <= w_sel_nxt;
            r_op         <= w_op_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_state_nxt = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; r_last_grant doubles as the
    // current winner index while an access is in flight.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_last_grant_nxt = r_last_grant;
        w_ack_nxt        = 2'b00;
        w_rdata_nxt      = r_rdata;
        w_sel_nxt        = r_sel;
        w_op_nxt         = r_op;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_sel_nxt        = 1'b1;
                    w_last_grant_nxt = w_grant[1];
                    w_cnt_nxt        = CNT_INIT;
                    w_op_nxt         = w_grant[1] ? i_op[1]  : i_op[0];
                    w_addr_nxt       = w_grant[1] ? i_addr1  : i_addr0;
                    w_wdata_nxt      = w_grant[1] ? i_wdata1 : i_wdata0;
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_sel_nxt = 1'b0;
                    w_ack_nxt = r_last_grant ? 2'b10 : 2'b01;
                    if (r_op == OP_READ) w_rdata_nxt = i_mem_rdata;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign o_ack        = r_ack;
    assign o_rdata      = r_rdata;
    assign o_mem_select = r_sel;
    assign o_mem_op     = r_op;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, op;
    logic [2:0] a0, a1;
    logic [7:0] w0, w1;
    logic [1:0] ack;
    logic [7:0] rdata, mem_wdata, mem_rdata;
    logic       sel, mop;
    logic [2:0] maddr;

    logic [7:0] mem [8];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(8), .ADDR_W(3), .ACCESS_CYCLES(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_op         (op),
        .i_addr0      (a0),
        .i_addr1      (a1),
        .i_wdata0     (w0),
        .i_wdata1     (w1),
        .o_ack        (ack),
        .o_rdata      (rdata),
        .o_mem_select (sel),
        .o_mem_op     (mop),
        .o_mem_addr   (maddr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[maddr];
    always @(posedge clk) if (sel && mop) mem[maddr] <= mem_wdata;

    typedef struct {
        logic       rst;
        logic [1:0] req, op;
        logic [2:0] a0, a1;
        logic [7:0] w0, w1;
        logic [1:0] e_ack;
        logic       e_sel, e_op;
        logic [2:0] e_addr;
        logic [7:0] e_wdata, e_rdata;
    } vec_t;

    vec_t vecs [22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_ord [4];
        int got, last_c;

        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[3] = 8'h3C;

        //           rst req    op     a0    a1    w0     w1     ack    sel  op   addr  wdata  rdata
        vecs[0]  = '{1, 2'b11, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 0,   0,   3'd0, 8'h00, 8'h00};
        vecs[1]  = '{1, 2'b11, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 0,   0,   3'd0, 8'h00, 8'h00};
        vecs[2]  = '{0, 2'b01, 2'b01, 3'd5, 3'd0, 8'hA5, 8'h00, 2'b00, 1,   1,   3'd5, 8'hA5, 8'h00};
        vecs[3]  = '{0, 2'b01, 2'b01, 3'd5, 3'd0, 8'hA5, 8'h00, 2'b00, 1,   1,   3'd5, 8'hA5, 8'h00};
        vecs[4]  = '{0, 2'b01, 2'b01, 3'd5, 3'd0, 8'hA5, 8'h00, 2'b01, 0,   1,   3'd5, 8'hA5, 8'h00};
        vecs[5]  = '{0, 2'b00, 2'b01, 3'd5, 3'd0, 8'hA5, 8'h00, 2'b00, 0,   1,   3'd5, 8'hA5, 8'h00};
        vecs[6]  = '{0, 2'b10, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 1,   0,   3'd3, 8'h00, 8'h00};
        vecs[7]  = '{0, 2'b10, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 1,   0,   3'd3, 8'h00, 8'h00};
        vecs[8]  = '{0, 2'b10, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b10, 0,   0,   3'd3, 8'h00, 8'h3C};
        vecs[9]  = '{0, 2'b00, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 0,   0,   3'd3, 8'h00, 8'h3C};
        vecs[10] = '{0, 2'b01, 2'b01, 3'd5, 3'd3, 8'h5A, 8'h00, 2'b00, 1,   1,   3'd5, 8'h5A, 8'h3C};
        vecs[11] = '{0, 2'b01, 2'b01, 3'd7, 3'd3, 8'h5A, 8'h00, 2'b00, 1,   1,   3'd5, 8'h5A, 8'h3C};
        vecs[12] = '{0, 2'b01, 2'b01, 3'd7, 3'd3, 8'h5A, 8'h00, 2'b01, 0,   1,   3'd5, 8'h5A, 8'h3C};
        vecs[13] = '{0, 2'b00, 2'b01, 3'd7, 3'd3, 8'h5A, 8'h00, 2'b00, 0,   1,   3'd5, 8'h5A, 8'h3C};
        vecs[14] = '{0, 2'b01, 2'b01, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 1,   1,   3'd5, 8'hA5, 8'h3C};
        vecs[15] = '{1, 2'b01, 2'b01, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 0,   0,   3'd0, 8'h00, 8'h00};
        vecs[16] = '{0, 2'b00, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 0,   0,   3'd0, 8'h00, 8'h00};
        vecs[17] = '{0, 2'b00, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 0,   0,   3'd0, 8'h00, 8'h00};
        vecs[18] = '{0, 2'b10, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 1,   0,   3'd3, 8'h00, 8'h00};
        vecs[19] = '{0, 2'b10, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 1,   0,   3'd3, 8'h00, 8'h00};
        vecs[20] = '{0, 2'b10, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b10, 0,   0,   3'd3, 8'h00, 8'h3C};
        vecs[21] = '{0, 2'b00, 2'b00, 3'd5, 3'd3, 8'hA5, 8'h00, 2'b00, 0,   0,   3'd3, 8'h00, 8'h3C};

`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_ord = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        rst = 1'b1; req = 2'b00; op = 2'b00;
        a0 = '0; a1 = '0; w0 = '0; w1 = '0;
        #2;

        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst; req = vecs[i].req; op = vecs[i].op;
            a0 = vecs[i].a0; a1 = vecs[i].a1; w0 = vecs[i].w0; w1 = vecs[i].w1;
            step();
            chk($sformatf("vec%0d {ack,sel,op,addr,wdata,rdata}", i),
                {9'd0, ack, sel, mop, maddr, mem_wdata, rdata},
                {9'd0, vecs[i].e_ack, vecs[i].e_sel, vecs[i].e_op,
                 vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_rdata});
        end

        // Contention: reset restores last_grant=1, then both request continuously.
        rst = 1'b1; req = 2'b11; op = 2'b00; a0 = 3'd1; a1 = 3'd2;
        step();
        rst = 1'b0;
        got = 0; last_c = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            step();
            if (ack != 2'b00) begin
                chk($sformatf("contention ack#%0d", got), 32'(ack), 32'(exp_ord[got]));
                if (got == 0) chk("contention first-ack latency", 32'(c), 32'd2);
                else          chk("contention ack spacing", 32'(c - last_c), 32'd4);
                last_c = c;
                got++;
            end
        end
        if (got < 4) begin
            n_vec++; n_miss++;
            $display("FAIL contention timeout: got %0d acks expected 4", got);
        end
        req = 2'b00;
        step();
        step();
        chk("post-contention idle {ack,sel}", {29'd0, ack, sel}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8x8-bit memory (8 words x 8 bits) between two requesters (index 0 and 1).
- Accepts one request at a time and arbitrates round-robin.
- Drives the memory select/op/address/write-data lines for a fixed access window, captures read data, and returns a one-cycle acknowledge to the winner.
- Sits between the client logic and the memory's control FSM/array.

Parameters:
- DATA_W, 8: memory word width.
- ADDR_W, 3: memory address width (8 words).
- ACCESS_CYCLES, 2: cycles o_mem_select is held high per access; legal range 1..15.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  2  per-requester request; held high until that requester's o_ack.
- i_op  input  2  per-requester op: 1 = write, 0 = read.
- i_addr0  input  ADDR_W  requester 0 address.
- i_addr1  input  ADDR_W  requester 1 address.
- i_wdata0  input  DATA_W  requester 0 write data.
- i_wdata1  input  DATA_W  requester 1 write data.
- o_ack  output  2  one-hot, one-cycle completion pulse.
- o_rdata  output  DATA_W  read data; valid only during the o_ack cycle of a read.
- o_mem_select  output  1  memory select.
- o_mem_op  output  1  memory op (1 = write).
- o_mem_addr  output  ADDR_W  memory address.
- o_mem_wdata  output  DATA_W  memory write data.
- i_mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous and active-high.
- Reset values: state IDLE; o_ack=0, o_rdata=0, o_mem_select=0, o_mem_op=0, o_mem_addr=0, o_mem_wdata=0; counter=0; last_grant=1, so requester 0 wins the first tie.
- All outputs are registered.
- States are IDLE, ACCESS, DONE.
- IDLE:
  - If no i_req is high, stay in IDLE.
  - If one i_req is high, grant that requester.
  - If both are high, grant the requester != last_grant.
  - On grant: latch op/addr/wdata into the o_mem_* registers, set o_mem_select=1, set last_grant=winner, counter=ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - o_mem_select stays 1 and the o_mem_* lines stay stable.
  - Counter decrements each cycle.
  - When counter==0: if read, capture i_mem_rdata into o_rdata; set o_mem_select=0 and o_ack[winner]=1; go to DONE.
- DONE:
  - o_ack pulse lasts exactly one cycle; o_rdata holds until the next read completes.
  - Next state is IDLE.
- Latency: request sampled at edge k -> select high in cycles k+1..k+ACCESS_CYCLES -> ack high in cycle k+ACCESS_CYCLES+1.
- Handshake:
  - Requester keeps i_op/addr/wdata stable while i_req is high.
  - Inputs are latched at grant; later changes are ignored until ack.
  - Requester drops i_req in the cycle after its ack. An i_req still high in IDLE is a new request.
- A requester that deasserts i_req mid-access is not aborted; the access completes and is acked.
- Back-to-back: with both requesting continuously, grants alternate 0,1,0,1 with a 2-cycle gap of o_mem_select low (DONE + IDLE).
- Reset mid-access: o_mem_select drops on the next edge, no ack is issued, and the access is lost.
- Counter width is 4 bits.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both request; last_grant is unused and requester 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Package mem_pkg holds:
  - DATA_W and ADDR_W constants.
  - state enum typedef arb_state_t {IDLE, ACCESS, DONE}.
  - OP_READ/OP_WRITE constants.
- Sub-module mem_arb_rr: combinational 2-way grant picker.
  - Inputs: req[1:0], last_grant.
  - Output: one-hot grant.
  - Contains the MEM_ARB_FIXED_PRIO_EN switch.
- mem_arbiter holds the FSM, counter and registers.

Test Plan:
- Reset: hold i_rst 2 cycles with i_req=2'b11 -> all outputs 0, no ack, o_mem_select=0.
- Single write: i_req=2'b01, op=1, addr0=3'd5, wdata0=8'hA5 at edge k -> o_mem_select=1 with addr 5 and wdata A5 in cycles k+1..k+2; o_ack=2'b01 in cycle k+3.
- Single read: requester 1 reads addr 3 while the memory model returns 8'h3C -> o_ack=2'b10 and o_rdata=8'h3C in cycle k+3; o_rdata holds 3C afterwards.
- Contention: i_req=2'b11 held continuously for 4 transactions -> ack order 01,10,01,10.
  - With MEM_ARB_FIXED_PRIO_EN defined -> ack order 01,01,01,01.
- Reset mid-access: assert i_rst in cycle k+1 of a write -> o_mem_select=0 from k+2; no o_ack; FSM back in IDLE.
- Input stability: change addr0 from 5 to 7 during ACCESS -> o_mem_addr stays 5 until ack.
